// File: rtl/spi_mem_if.sv
// Fabric-side request/response and SPI pin bundle for the SPI memory master.
// The master modport is the controller's view; the slave modport is the fabric/pin side.
interface spi_mem_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, rw, addr, wdata, miso,
        output busy, done, rdata, sclk, cs, mosi
    );

    modport slave (
        output start, rw, addr, wdata, miso,
        input  busy, done, rdata, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_mem_master.sv
// Mode-0 SPI master for single-byte read/write to the on-board SPI memory.
// Frame is {addr, rw, data} MSB first; read data is the last byte shifted in on miso.
module spi_mem_master #(
    parameter int CLK_DIV = 25,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic      clk,
    input  logic      reset,
    spi_mem_if.master bus
);
    localparam int TX_W  = ADDR_W + 1 + DATA_W;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BC_W  = $clog2(TX_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DIV_W-1:0]  div;
    logic              tick;
    logic [BC_W-1:0]   bitcnt;
    logic [TX_W-1:0]   tx;
    logic [DATA_W-1:0] rx;
    logic [DATA_W-1:0] rdata_q;
    logic              rw_q;
    logic              cs_q;
    logic              sclk_q;
    logic              done_q;

    assign tick = (div == DIV_W'(CLK_DIV - 1));

    // Half-period divider runs only while a transaction is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (state == IDLE || tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start) state_nx = SETUP;
            SETUP: if (tick) state_nx = SHIFT;
            SHIFT: if (tick && sclk_q && bitcnt == BC_W'(TX_W - 1)) state_nx = HOLD;
            HOLD:  if (tick) state_nx = GAP;
            GAP:   if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Serial datapath: rising tick samples miso, falling tick shifts tx so mosi is the MSB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            tx      <= '0;
            rx      <= '0;
            rw_q    <= 1'b0;
            bitcnt  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx     <= {bus.addr, bus.rw, bus.wdata};
                        rw_q   <= bus.rw;
                        cs_q   <= 1'b0;
                        sclk_q <= 1'b0;
                        bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx     <= {rx[DATA_W-2:0], bus.miso};
                        end else begin
                            sclk_q <= 1'b0;
                            tx     <= {tx[TX_W-2:0], 1'b0};
                            bitcnt <= bitcnt + BC_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_q   <= 1'b1;
                        done_q <= 1'b1;
                        if (rw_q) begin
                            rdata_q <= rx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // tx empties to zero after the last bit, so mosi rests low outside the frame
    assign bus.mosi  = tx[TX_W-1];
    assign bus.sclk  = sclk_q;
    assign bus.cs    = cs_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: a fast instance (CLK_DIV=2) for the bulk of the checks
// and a default-divider instance for absolute timing; a slave model feeds miso.
module tb_spi_mem_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_mem_if #(.ADDR_W(7), .DATA_W(8)) b2 ();
  spi_mem_if #(.ADDR_W(7), .DATA_W(8)) b25 ();

  spi_mem_master #(.CLK_DIV(2), .ADDR_W(7), .DATA_W(8)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  spi_mem_master #(.ADDR_W(7), .DATA_W(8)) dut25 (.clk(clk), .reset(reset), .bus(b25));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_rdata = 8'h00;

  // Monitor and slave model for the fast instance
  int rise_cnt = 0, fall_cnt = 0, cs_low = 0, hi_run = 0, min_gap = 1000;
  int done_cnt = 0, tog_err = 0, bd_err = 0;
  bit seen = 1'b0;
  logic sclk_q = 1'b0, cs_q = 1'b1;
  logic [15:0] mosi_word = '0;
  logic [15:0] slave_word = '0;

  always @(negedge clk) begin
    int nf;
    sclk_q <= b2.sclk;
    cs_q <= b2.cs;
    done_cnt <= done_cnt + int'(b2.done);
    if (b2.cs && cs_q && (b2.sclk !== sclk_q)) tog_err <= tog_err + 1;
    if (!b2.cs && !b2.busy && !b2.done) bd_err <= bd_err + 1;
    nf = fall_cnt;
    if (!b2.cs && cs_q) begin
      nf = 0;
      rise_cnt <= 0;
      cs_low <= 1;
      if (seen && hi_run < min_gap) min_gap <= hi_run;
      seen <= 1'b1;
      hi_run <= 0;
    end else begin
      if (!b2.cs) cs_low <= cs_low + 1;
      else hi_run <= hi_run + 1;
      if (b2.sclk && !sclk_q) begin
        rise_cnt <= rise_cnt + 1;
        mosi_word <= {mosi_word[14:0], b2.mosi};
      end
      if (!b2.sclk && sclk_q) nf = fall_cnt + 1;
    end
    fall_cnt <= nf;
    b2.miso <= (nf < 16) ? slave_word[15-nf] : 1'b0;
  end

  // Monitor and slave model for the default-divider instance
  int cyc = 0, rise25 = 0, fall25 = 0, per25 = 0, last25 = 0;
  logic s25_q = 1'b0, c25_q = 1'b1;
  logic [15:0] slave25 = '0;

  always @(negedge clk) begin
    int nf25;
    cyc <= cyc + 1;
    s25_q <= b25.sclk;
    c25_q <= b25.cs;
    if (b25.sclk && !s25_q) begin
      rise25 <= rise25 + 1;
      per25 <= cyc - last25;
      last25 <= cyc;
    end
    nf25 = fall25;
    if (!b25.cs && c25_q) begin
      nf25 = 0;
      rise25 <= 0;
    end else if (!b25.sclk && s25_q) begin
      nf25 = fall25 + 1;
    end
    fall25 <= nf25;
    b25.miso <= (nf25 < 16) ? slave25[15-nf25] : 1'b0;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One transaction on the fast instance, checked against the frame/latency rules
  task automatic txn(input logic r, input logic [6:0] a, input logic [7:0] w,
                     input logic [7:0] sb, input bit pulse, input string tag);
    int n;
    int d0;
    logic [7:0] pre;
    logic [7:0] old_exp;
    slave_word = {8'($urandom), sb};
    d0 = done_cnt;
    old_exp = exp_rdata;
    pre = 8'hxx;
    b2.rw = r;
    b2.addr = a;
    b2.wdata = w;
    b2.start = 1'b1;
    step();
    n = 1;
    b2.start = 1'b0;
    b2.rw = ~r;
    b2.addr = ~a;
    b2.wdata = ~w;
    while (!b2.done && n < 300) begin
      if (n == 68) pre = b2.rdata;
      b2.start = pulse && (n == 10 || n == 40);
      step();
      n++;
    end
    b2.start = 1'b0;
    if (r) exp_rdata = sb;
    chk({tag, " latency"}, n, 69);
    chk({tag, " rises"}, rise_cnt, 16);
    chk({tag, " mosi"}, {16'h0, mosi_word}, {16'h0, a, r, w});
    chk({tag, " cs_low"}, cs_low, 68);
    chk({tag, " rdata_pre"}, {24'h0, pre}, {24'h0, old_exp});
    chk({tag, " rdata"}, {24'h0, b2.rdata}, {24'h0, exp_rdata});
    repeat (45) step();
    chk({tag, " dones"}, done_cnt - d0, 1);
    chk({tag, " idle"}, {30'h0, b2.busy, b2.cs}, 32'h1);
  endtask

  initial begin
    int n;
    int k;
    int d0;
    int dn[3];
    b2.start = 1'b0; b2.rw = 1'b0; b2.addr = '0; b2.wdata = '0;
    b25.start = 1'b0; b25.rw = 1'b0; b25.addr = '0; b25.wdata = '0;
    reset = 1'b1;
    step();
    step();
    chk("reset cs", b2.cs, 1);
    chk("reset sclk", b2.sclk, 0);
    chk("reset mosi", b2.mosi, 0);
    chk("reset busy", b2.busy, 0);
    chk("reset done", b2.done, 0);
    chk("reset rdata", b2.rdata, 0);
    chk("reset cs25", b25.cs, 1);
    reset = 1'b0;
    repeat (3) step();

    txn(1'b0, 7'h15, 8'hA5, 8'h77, 1'b0, "wr15");
    txn(1'b1, 7'h15, 8'h00, 8'h3C, 1'b0, "rd15");
    txn(1'b0, 7'h40, 8'h12, 8'hEE, 1'b0, "wr_hold1");
    txn(1'b0, 7'h7F, 8'hFF, 8'h01, 1'b1, "wr_pulse");
    txn(1'b1, 7'h00, 8'h00, 8'hC9, 1'b1, "rd_pulse");

    // start held high: back-to-back transactions separated by the gap
    d0 = done_cnt;
    slave_word = 16'h1234;
    b2.rw = 1'b0; b2.addr = 7'h11; b2.wdata = 8'h99; b2.start = 1'b1;
    n = 0;
    k = 0;
    while (k < 3 && n < 1000) begin
      step();
      n++;
      if (b2.done) begin
        dn[k] = n;
        k++;
      end
    end
    b2.start = 1'b0;
    chk("b2b count", k, 3);
    chk("b2b first", dn[0], 69);
    chk("b2b space1", dn[1] - dn[0], 71);
    chk("b2b space2", dn[2] - dn[1], 71);
    repeat (80) step();
    chk("b2b dones", done_cnt - d0, 3);
    chk("b2b idle", b2.busy, 0);

    for (int i = 0; i < 8; i++) begin
      txn(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, "rand");
    end
    txn(1'b1, 7'h2B, 8'h00, 8'h5A, 1'b0, "rd_prereset");

    // reset at the fifth sclk rise of a read
    d0 = done_cnt;
    slave_word = 16'h5AC3;
    b2.rw = 1'b1; b2.addr = 7'h33; b2.wdata = 8'h00; b2.start = 1'b1;
    step();
    b2.start = 1'b0;
    n = 0;
    while (rise_cnt != 5 && n < 100) begin
      step();
      n++;
    end
    reset = 1'b1;
    #1;
    chk("rst cs", b2.cs, 1);
    chk("rst sclk", b2.sclk, 0);
    chk("rst busy", b2.busy, 0);
    chk("rst rdata", b2.rdata, 0);
    step();
    step();
    reset = 1'b0;
    exp_rdata = 8'h00;
    repeat (80) step();
    chk("rst no done", done_cnt - d0, 0);
    txn(1'b0, 7'h2A, 8'h5C, 8'hFF, 1'b0, "post_rst_wr");

    // default divider: absolute latency and sclk period
    slave25 = 16'h00B6;
    b25.rw = 1'b1; b25.addr = 7'h6D; b25.wdata = 8'h00; b25.start = 1'b1;
    step();
    n = 1;
    b25.start = 1'b0;
    while (!b25.done && n < 2000) begin
      step();
      n++;
    end
    chk("d25 latency", n, 851);
    chk("d25 period", per25, 50);
    chk("d25 rises", rise25, 16);
    chk("d25 rdata", b25.rdata, 8'hB6);
    repeat (40) step();
    chk("d25 idle", b25.busy, 0);

    chk("sclk toggles with cs high", tog_err, 0);
    chk("busy/done low during cs", bd_err, 0);
    chk("min cs gap", min_gap, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
